// File: rtl/vector5_decoder_if.sv
// vector5_decoder_if
//   Bundles the frame input handshake, the result output handshake and the
//   error-counter controls of vector5_decoder.
//   master : frame producer / result consumer (drives in_*, anchor, out_ready, clr_cnt)
//   slave  : the decoder (drives in_ready, out_*, err, err_row, err_count)
interface vector5_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [24:0]          in_bits;
    logic                 anchor;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_bits;
    logic                 err;
    logic [2:0]           err_row;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 clr_cnt;

    modport master (
        output in_valid, in_bits, anchor, out_ready, clr_cnt,
        input  in_ready, out_valid, out_bits, err, err_row, err_count
    );

    modport slave (
        input  in_valid, in_bits, anchor, out_ready, clr_cnt,
        output in_ready, out_valid, out_bits, err, err_row, err_count
    );
endinterface

// File: rtl/vector5_decoder.sv
// vector5_decoder
//   Reconstructs a 5-bit pattern {a,b,c,d,e} from a 25-bit pairwise-equality
//   matrix, relative to an anchor value for a. The matrix is checked one row
//   per cycle; the first inconsistent row is reported and rejected frames are
//   counted in a saturating counter.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : vector5_decoder_if.slave (frame in, result out, counter clear)
//
//   state | meaning
//   IDLE  | waiting for a frame, in_ready=1
//   CHECK | checking matrix rows 0..4, one per cycle
//   DONE  | result presented, waiting for out_ready
module vector5_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vector5_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [24:0]          bits_q, bits_d;
    logic [4:0]           x_q, x_d;
    logic [2:0]           row_q, row_d;
    logic                 err_q, err_d;
    logic [2:0]           err_row_q, err_row_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]           row_bits;
    logic                 x_r;
    logic [4:0]           row_exp;

    // Row r occupies bits 24-5r down to 20-5r, column 0 in the MSB.
    always_comb begin
        row_bits = bits_q[24:20];
        x_r      = x_q[4];
        unique case (row_q)
            3'd0: begin row_bits = bits_q[24:20]; x_r = x_q[4]; end
            3'd1: begin row_bits = bits_q[19:15]; x_r = x_q[3]; end
            3'd2: begin row_bits = bits_q[14:10]; x_r = x_q[2]; end
            3'd3: begin row_bits = bits_q[9:5];   x_r = x_q[1]; end
            3'd4: begin row_bits = bits_q[4:0];   x_r = x_q[0]; end
            default: begin row_bits = bits_q[24:20]; x_r = x_q[4]; end
        endcase
        // x_j == x_r is x_j itself when x_r=1, its complement otherwise.
        row_exp = x_r ? x_q : ~x_q;
    end

    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        x_d       = x_q;
        row_d     = row_q;
        err_d     = err_q;
        err_row_d = err_row_q;
        cnt_d     = cnt_q;

        if (bus.clr_cnt) begin
            cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bits_d    = bus.in_bits;
                    // a is the anchor by definition; the diagonal bit is not
                    // trusted here so a corrupted diagonal shows up as a row-0 error.
                    x_d[4]    = bus.anchor;
                    x_d[3:0]  = bus.anchor ? bus.in_bits[23:20] : ~bus.in_bits[23:20];
                    row_d     = 3'd0;
                    err_d     = 1'b0;
                    err_row_d = 3'd0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if ((row_bits != row_exp) && !err_q) begin
                    err_d     = 1'b1;
                    err_row_d = row_q;
                end
                if (row_q == 3'd4) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (err_q && !bus.clr_cnt && (cnt_q != '1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            x_q       <= '0;
            row_q     <= '0;
            err_q     <= 1'b0;
            err_row_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            x_q       <= x_d;
            row_q     <= row_d;
            err_q     <= err_d;
            err_row_q <= err_row_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bits  = x_q;
    assign bus.err       = err_q;
    assign bus.err_row   = err_row_q;
    assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_vector5_decoder.sv
// tb_vector5_decoder
//   Directed frames with hand-computed patterns, error rows and counter values.
//   The decoder is built with a 2-bit error counter so saturation is reachable.
module tb_vector5_decoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    vector5_decoder_if #(.ERR_CNT_W(2)) bus ();

    vector5_decoder #(.ERR_CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame, check latency and result, optionally stall, then
    // complete the handshake (optionally with clr_cnt) and check the counter.
    task automatic run_frame(input logic [24:0] bits, input logic anc,
                             input logic [4:0] e_bits, input logic e_err,
                             input logic [2:0] e_row, input int e_cnt,
                             input int stall, input logic clr);
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_bits   = bits;
        bus.anchor    = anc;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        // keep presenting a different frame; it must be ignored outside IDLE
        bus.in_bits = ~bits;
        bus.anchor  = ~anc;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
        end
        check_eq("out_valid_early", 32'(bus.out_valid), 32'd0);
        check_eq("in_ready_check",  32'(bus.in_ready),  32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("out_valid_lat", 32'(bus.out_valid), 32'd1);
        check_eq("out_bits",      32'(bus.out_bits),  32'(e_bits));
        check_eq("err",           32'(bus.err),       32'(e_err));
        check_eq("err_row",       32'(bus.err_row),   32'(e_row));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stall_ready", 32'(bus.in_ready),  32'd0);
            check_eq("stall_bits",  32'(bus.out_bits),  32'(e_bits));
            check_eq("stall_err",   32'(bus.err),       32'(e_err));
        end
        bus.out_ready = 1'b1;
        bus.clr_cnt   = clr;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.clr_cnt   = 1'b0;
        check_eq("out_valid_hs", 32'(bus.out_valid), 32'd0);
        check_eq("in_ready_hs",  32'(bus.in_ready),  32'd1);
        check_eq("err_count",    32'(bus.err_count), 32'(e_cnt));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.anchor    = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_cnt   = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_bits",  32'(bus.out_bits),  32'd0);
        check_eq("rst_err",       32'(bus.err),       32'd0);
        check_eq("rst_err_row",   32'(bus.err_row),   32'd0);
        check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // bits,        anchor, out_bits,  err,  row,  cnt, stall, clr
        run_frame(25'h164DAC9, 1'b1, 5'b10110, 1'b0, 3'd0, 0, 0,  1'b0);
        run_frame(25'h164DAC9, 1'b0, 5'b01001, 1'b0, 3'd0, 0, 0,  1'b0);
        run_frame(25'h1FFFFFF, 1'b1, 5'b11111, 1'b0, 3'd0, 0, 0,  1'b0);
        run_frame(25'h064DAC9, 1'b1, 5'b10110, 1'b1, 3'd0, 1, 0,  1'b0);
        run_frame(25'h164DEC9, 1'b1, 5'b10110, 1'b1, 3'd2, 2, 10, 1'b0);
        run_frame(25'h064DAC9, 1'b0, 5'b01001, 1'b1, 3'd0, 3, 0,  1'b0);
        run_frame(25'h164DEC9, 1'b1, 5'b10110, 1'b1, 3'd2, 3, 0,  1'b0);
        run_frame(25'h064DAC9, 1'b1, 5'b10110, 1'b1, 3'd0, 0, 0,  1'b1);
        run_frame(25'h164DAC8, 1'b1, 5'b10110, 1'b1, 3'd4, 1, 0,  1'b0);

        // reset during the third CHECK cycle of an error frame
        bus.in_valid  = 1'b1;
        bus.in_bits   = 25'h064DAC9;
        bus.anchor    = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("mid_rst_out_bits",  32'(bus.out_bits),  32'd0);
        check_eq("mid_rst_err",       32'(bus.err),       32'd0);
        check_eq("mid_rst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check_eq("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        run_frame(25'h164DAC9, 1'b1, 5'b10110, 1'b0, 3'd0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
